cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  synchronous active-high reset.
REQ-003 SHALL have ports: i_pmem_read  input  1  I-cache line-fill request; i_pmem_address  input  32  I-cache line address.
REQ-004 SHALL have ports: i_pmem_rdata  output  256  filled line; i_pmem_resp  output  1  one-cycle completion pulse to I-cache.
REQ-005 SHALL have ports: d_pmem_read  input  1; d_pmem_write  input  1; d_pmem_address  input  32; d_pmem_wdata  input  256  D-cache fill/writeback request.
REQ-006 SHALL have ports: d_pmem_rdata  output  256; d_pmem_resp  output  1  one-cycle completion pulse to D-cache.
REQ-007 SHALL have ports: mem_read  output  1; mem_write  output  1; mem_address  output  32; mem_wdata  output  64  physical-memory burst master.
REQ-008 SHALL have ports: mem_rdata  input  64; mem_resp  input  1  one pulse per accepted 64-bit beat.

Function
REQ-009 SHALL implement FSM states IDLE, I_READ, D_READ, D_WRITE, DONE_I, DONE_D.
REQ-010 IDLE: d_pmem_write SHALL grant D_WRITE; else d_pmem_read SHALL grant D_READ; else i_pmem_read SHALL grant I_READ; else remain IDLE.
REQ-011 D-side SHALL have priority over I-side when both are requesting in the same IDLE cycle.
REQ-012 d_pmem_read and d_pmem_write asserted together SHALL be treated as write.
REQ-013 On grant, the arbiter SHALL latch the requester address with bits [4:0] forced to 0, and for D_WRITE the 256-bit wdata; later requester input changes SHALL be ignored until DONE.
REQ-014 In I_READ/D_READ, mem_read SHALL be 1; in D_WRITE, mem_write SHALL be 1; both SHALL be held continuously for the whole burst; never both at once.
REQ-015 mem_address SHALL be the latched aligned address for the entire burst; 0 in IDLE.
REQ-016 Burst SHALL be exactly 4 beats; a 2-bit beat counter SHALL start at 0 on grant and increment on each mem_resp.
REQ-017 Read beat n (n=0..3) SHALL be stored in line buffer bits [64n+63:64n] on the mem_resp cycle.
REQ-018 Write: mem_wdata SHALL be latched wdata bits [64n+63:64n] for current beat n; 0 when not in D_WRITE.
REQ-019 On the mem_resp with counter==3, FSM SHALL go to DONE_I (from I_READ) or DONE_D (from D_READ/D_WRITE), counter to 0, and mem_read/mem_write SHALL be 0 from the next cycle.
REQ-020 DONE_I SHALL assert i_pmem_resp for exactly one cycle; DONE_D SHALL assert d_pmem_resp for exactly one cycle; both states SHALL then go to IDLE unconditionally.
REQ-021 Response latency SHALL be 1 cycle after the 4th mem_resp; minimum grant-to-resp is 5 cycles with mem_resp tied high.
REQ-022 i_pmem_rdata and d_pmem_rdata SHALL both be driven from the line buffer, valid in the resp cycle and held until the next read burst writes beat 0.
REQ-023 A request still asserted in the DONE cycle SHALL NOT re-trigger; it is sampled only in IDLE.
REQ-024 mem_resp outside I_READ/D_READ/D_WRITE SHALL be ignored.
REQ-025 i_pmem_resp and d_pmem_resp SHALL never be 1 in the same cycle.

Reset
REQ-026 rst high at a clock edge SHALL force IDLE, counter 0, line buffer 0, latched address/data 0, from any state including mid-burst.
REQ-027 During and after reset until a new grant: mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, i_pmem_resp=0, d_pmem_resp=0, rdata outputs=0.
REQ-028 A burst interrupted by reset SHALL NOT produce any resp pulse.

Verification
REQ-029 I-fill: i_pmem_read=1, addr 0x0000_1234, mem_resp high 4 cycles with rdata 0x11..,0x22..,0x33..,0x44.. -> mem_address=0x0000_1220, i_pmem_resp one cycle, i_pmem_rdata={0x44..,0x33..,0x22..,0x11..}.
REQ-030 Contention: i_pmem_read and d_pmem_read rise same cycle -> D burst first, d_pmem_resp, then I burst, i_pmem_resp; no overlap.
REQ-031 Writeback: d_pmem_write=1, wdata=256'h(D3,D2,D1,D0), mem_resp with 2-cycle gaps -> mem_wdata D0,D1,D2,D3 in order, mem_write held 1 throughout incl. gaps, d_pmem_resp after 4th beat.
REQ-032 Mid-burst reset: rst after 2nd beat of D_READ -> next cycle mem_read=0, no d_pmem_resp, next request restarts at beat 0.
REQ-033 Latch check: change d_pmem_address/wdata mid-write -> mem_address and beats unchanged from grant values.
REQ-034 Held request: requester keeps i_pmem_read=1 one cycle past i_pmem_resp -> exactly one extra IDLE-sampled burst only if still high in IDLE, never a resp in consecutive cycles.

Source files
------------

// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Arbitrates between an I-cache line-fill port and a D-cache fill/writeback
//   port. It drives a single physical-memory burst master. Each granted
//   request moves one 256-bit line as four 64-bit beats. The D-side wins over
//   the I-side when both request in the same idle cycle. A D-side request
//   with both read and write asserted is treated as a writeback.
//
// Ports
//   clk, rst                    clock and synchronous active-high reset
//   i_pmem_read/address         I-cache fill request and line address
//   i_pmem_rdata/resp           filled line and one-cycle completion pulse
//   d_pmem_read/write/address   D-cache fill or writeback request
//   d_pmem_wdata                line to write back
//   d_pmem_rdata/resp           filled line and one-cycle completion pulse
//   mem_read/write/address      burst master command, held for the whole burst
//   mem_wdata                   current write beat
//   mem_rdata/resp              memory beat data and per-beat acknowledge

module cache_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_pmem_read,
  input  logic [31:0]  i_pmem_address,
  output logic [255:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [31:0]  d_pmem_address,
  input  logic [255:0] d_pmem_wdata,
  output logic [255:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [63:0]  mem_wdata,
  input  logic [63:0]  mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_READ  = 3'd1,
    D_READ  = 3'd2,
    D_WRITE = 3'd3,
    DONE_I  = 3'd4,
    DONE_D  = 3'd5
  } state_t;

  state_t         r_state;
  logic [1:0]     r_beat;
  logic [31:0]    r_addr;
  logic [255:0]   r_wdata;
  logic [255:0]   r_line;
  logic           r_mem_read;
  logic           r_mem_write;
  logic           r_i_resp;
  logic           r_d_resp;
  logic [63:0]    w_mem_wdata;

  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_beat      <= 2'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 256'd0;
      r_line      <= 256'd0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_i_resp    <= 1'b0;
      r_d_resp    <= 1'b0;
    end else begin
      // Completion pulses last exactly one cycle: they are set only on the
      // final beat and dropped here on the following edge.
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          r_beat <= 2'd0;
          if (d_pmem_write) begin
            r_state     <= D_WRITE;
            r_addr      <= d_pmem_address & LINE_MASK;
            r_wdata     <= d_pmem_wdata;
            r_mem_write <= 1'b1;
          end else if (d_pmem_read) begin
            r_state    <= D_READ;
            r_addr     <= d_pmem_address & LINE_MASK;
            r_mem_read <= 1'b1;
          end else if (i_pmem_read) begin
            r_state    <= I_READ;
            r_addr     <= i_pmem_address & LINE_MASK;
            r_mem_read <= 1'b1;
          end
        end
        I_READ, D_READ, D_WRITE: begin
          if (mem_resp) begin
            if (r_state != D_WRITE) begin
              r_line[{r_beat, 6'b0} +: 64] <= mem_rdata;
            end
            // Two-bit counter wraps back to 0 on the fourth beat.
            r_beat <= r_beat + 2'd1;
            if (r_beat == 2'd3) begin
              r_mem_read  <= 1'b0;
              r_mem_write <= 1'b0;
              r_addr      <= 32'd0;
              if (r_state == I_READ) begin
                r_state  <= DONE_I;
                r_i_resp <= 1'b1;
              end else begin
                r_state  <= DONE_D;
                r_d_resp <= 1'b1;
              end
            end
          end
        end
        // Requests are not sampled here, so a request still high in the
        // completion cycle cannot start a new burst until IDLE sees it.
        DONE_I, DONE_D: r_state <= IDLE;
        default:        r_state <= IDLE;
      endcase
    end
  end

  // The write beat is selected from the latched line, so the requester may
  // change its inputs freely once the burst is granted.
  assign w_mem_wdata = (r_state == D_WRITE) ? r_wdata[{r_beat, 6'b0} +: 64] : 64'd0;

  assign mem_read     = r_mem_read;
  assign mem_write    = r_mem_write;
  assign mem_address  = r_addr;
  assign mem_wdata    = w_mem_wdata;
  assign i_pmem_rdata = r_line;
  assign d_pmem_rdata = r_line;
  assign i_pmem_resp  = r_i_resp;
  assign d_pmem_resp  = r_d_resp;

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomised scoreboard bench for cache_arbiter. A driver issues cache
// requests and pushes the expected bursts. A memory responder serves the
// bus and records what it saw. A monitor pops both on every completion pulse.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_pmem_read = 1'b0;
  logic [31:0]  i_pmem_address = 32'd0;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read = 1'b0;
  logic         d_pmem_write = 1'b0;
  logic [31:0]  d_pmem_address = 32'd0;
  logic [255:0] d_pmem_wdata = 256'd0;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata = 64'd0;
  logic         mem_resp = 1'b0;

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  typedef struct packed {
    bit           is_i;
    bit           is_wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } burst_t;

  burst_t       exp_q[$];
  burst_t       obs_q[$];
  logic [255:0] model_mem [bit [31:0]];
  logic [255:0] resp_mem  [bit [31:0]];

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;
  int resp_pct = 100;
  int gap_cfg = 0;
  bit idle_noise = 1'b0;
  bit mon_en = 1'b0;
  int beat_total = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Untouched memory lines hold a fixed pattern derived from their address.
  function automatic logic [255:0] dflt_line(input bit [31:0] a);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = a ^ (32'h9E37_79B9 * 32'(k + 1));
    return v;
  endfunction

  function automatic logic [255:0] model_get(input bit [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return dflt_line(a);
  endfunction

  function automatic logic [255:0] resp_get(input bit [31:0] a);
    if (resp_mem.exists(a)) return resp_mem[a];
    return dflt_line(a);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  // Memory responder: serves beats from its own copy of memory and records
  // every completed burst as it appeared on the bus.
  initial begin
    int     cnt;
    int     wait_n;
    bit     go;
    burst_t cur;
    logic [255:0] line;
    cnt = 0;
    wait_n = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      mem_resp  = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (mon_en && mem_read && mem_write) chk("read_write_exclusive", 256'(1), 256'(0));
      if (!mem_read && !mem_write) begin
        cnt = 0;
        wait_n = 0;
        if (idle_noise && $urandom_range(0, 9) == 0) mem_resp = 1'b1;
      end else begin
        if (cnt == 0) begin
          cur.is_i  = 1'b0;
          cur.is_wr = mem_write;
          cur.addr  = mem_address;
          cur.data  = '0;
        end else begin
          chk("burst_cmd_held", 256'({mem_write, mem_read}), cur.is_wr ? 256'(2) : 256'(1));
          chk("burst_addr_stable", 256'(mem_address), 256'(cur.addr));
        end
        if (gap_cfg > 0) begin
          go = (wait_n == gap_cfg);
          wait_n = go ? 0 : wait_n + 1;
        end else begin
          go = ($urandom_range(1, 100) <= resp_pct);
        end
        if (go) begin
          mem_resp = 1'b1;
          if (cur.is_wr) begin
            cur.data[64*cnt +: 64] = mem_wdata;
          end else begin
            line = resp_get(cur.addr);
            mem_rdata = line[64*cnt +: 64];
          end
          cnt++;
          beat_total++;
          if (cnt == 4) begin
            if (cur.is_wr) resp_mem[cur.addr] = cur.data;
            obs_q.push_back(cur);
            cnt = 0;
          end
        end
      end
    end
  end

  // Monitor: checks every completion against the scoreboard.
  initial begin
    burst_t e;
    burst_t o;
    logic   prev_resp;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (i_pmem_resp || d_pmem_resp) begin
          chk("resp_exclusive", 256'(i_pmem_resp & d_pmem_resp), 256'(0));
          chk("resp_not_back_to_back", 256'(prev_resp), 256'(0));
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", 256'(1), 256'(0));
          end else begin
            e = exp_q.pop_front();
            n_txn++;
            chk("resp_side_i", 256'(i_pmem_resp), 256'(e.is_i));
            if (obs_q.size() == 0) begin
              chk("burst_seen", 256'(0), 256'(1));
            end else begin
              o = obs_q.pop_front();
              chk("burst_kind_wr", 256'(o.is_wr), 256'(e.is_wr));
              chk("burst_addr", 256'(o.addr), 256'(e.addr));
              if (e.is_wr) chk("write_beats", o.data, e.data);
            end
            if (!e.is_wr) begin
              chk(e.is_i ? "i_rdata" : "d_rdata", e.is_i ? i_pmem_rdata : d_pmem_rdata, e.data);
              chk("shared_rdata", e.is_i ? d_pmem_rdata : i_pmem_rdata, e.data);
            end
            $display("txn %0d: %s %s addr=%h", n_txn, e.is_i ? "I" : "D",
                     e.is_wr ? "write" : "read", e.addr);
          end
        end else if (!mem_read && !mem_write) begin
          chk("idle_mem_address", 256'(mem_address), 256'(0));
        end
        if (!mem_write) chk("mem_wdata_zero", 256'(mem_wdata), 256'(0));
        prev_resp = i_pmem_resp | d_pmem_resp;
      end
    end
  end

  bit abort_run = 1'b0;

  // Issues one arbitration scenario, pushes its expected bursts in the order
  // the arbiter must serve them, and services completion pulses.
  task automatic run_txn(input bit req_i, input bit req_dr, input bit req_dw,
                         input bit hold_i, input bit scramble,
                         input logic [31:0] ai, input logic [31:0] ad,
                         input logic [255:0] wd, output int lat);
    burst_t e;
    int n_exp;
    int seen;
    int cyc;
    int hold_cnt;
    bit held;
    n_exp = 0;
    seen = 0;
    cyc = 0;
    hold_cnt = 0;
    held = 1'b0;
    lat = -1;
    if (req_dr || req_dw) begin
      e.is_i  = 1'b0;
      e.is_wr = req_dw;
      e.addr  = {ad[31:5], 5'd0};
      if (req_dw) begin
        e.data = wd;
        model_mem[e.addr] = wd;
      end else begin
        e.data = model_get(e.addr);
      end
      exp_q.push_back(e);
      n_exp++;
    end
    if (req_i) begin
      e.is_i  = 1'b1;
      e.is_wr = 1'b0;
      e.addr  = {ai[31:5], 5'd0};
      e.data  = model_get(e.addr);
      exp_q.push_back(e);
      n_exp++;
      if (hold_i) begin
        exp_q.push_back(e);
        n_exp++;
      end
    end
    @(negedge clk);
    i_pmem_read    = req_i;
    i_pmem_address = ai;
    d_pmem_read    = req_dr;
    d_pmem_write   = req_dw;
    d_pmem_address = ad;
    d_pmem_wdata   = wd;
    while (seen < n_exp) begin
      @(negedge clk);
      cyc++;
      if (cyc > 400) begin
        chk("txn_timeout", 256'(seen), 256'(n_exp));
        abort_run = 1'b1;
        break;
      end
      if (d_pmem_resp) begin
        seen++;
        if (lat < 0) lat = cyc;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
      end
      if (i_pmem_resp) begin
        seen++;
        if (lat < 0) lat = cyc;
        if (hold_i && !held) begin
          held = 1'b1;
          hold_cnt = 2;
        end else begin
          i_pmem_read = 1'b0;
        end
      end else if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) i_pmem_read = 1'b0;
      end
      if (scramble && (req_dr || req_dw)) begin
        d_pmem_address = $urandom;
        d_pmem_wdata   = rand256();
      end
      if (scramble && req_i && !req_dr && !req_dw && !hold_i) i_pmem_address = $urandom;
    end
    i_pmem_read  = 1'b0;
    d_pmem_read  = 1'b0;
    d_pmem_write = 1'b0;
  endtask

  initial begin
    int lat;
    int start;
    int typ;
    logic [255:0] fill;
    logic [31:0]  ai;
    logic [31:0]  ad;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_mem_read", 256'(mem_read), 256'(0));
    chk("rst_mem_write", 256'(mem_write), 256'(0));
    chk("rst_mem_address", 256'(mem_address), 256'(0));
    chk("rst_mem_wdata", 256'(mem_wdata), 256'(0));
    chk("rst_resp", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));
    chk("rst_i_rdata", i_pmem_rdata, 256'd0);
    chk("rst_d_rdata", d_pmem_rdata, 256'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // I-fill with back-to-back beats: alignment, beat order, minimum latency.
    fill = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    model_mem[32'h0000_1220] = fill;
    resp_mem[32'h0000_1220]  = fill;
    run_txn(1, 0, 0, 0, 0, 32'h0000_1234, 32'd0, 256'd0, lat);
    chk("min_latency", 256'(lat), 256'(5));
    @(negedge clk);
    chk("rdata_held_after_resp", i_pmem_rdata, fill);

    // Contention: D read served before I read.
    run_txn(1, 1, 0, 0, 0, 32'h0000_2040, 32'h0000_3067, 256'd0, lat);

    // Writeback with two idle cycles between beats, inputs scrambled after
    // grant, then the same line read back.
    gap_cfg = 2;
    run_txn(0, 0, 1, 0, 1, 32'd0, 32'h0000_5A5F, rand256(), lat);
    gap_cfg = 0;
    run_txn(0, 1, 0, 0, 0, 32'd0, 32'h0000_5A40, 256'd0, lat);

    // Read and write together count as a write.
    run_txn(0, 1, 1, 0, 0, 32'd0, 32'h0000_6011, rand256(), lat);

    // I request held one cycle into IDLE produces exactly one extra burst.
    run_txn(1, 0, 0, 1, 0, 32'h0000_7003, 32'd0, 256'd0, lat);

    // Reset after the second beat of a D read aborts it silently.
    start = beat_total;
    @(negedge clk);
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_8020;
    for (int k = 0; k < 50 && beat_total < start + 2; k++) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    d_pmem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_mem_read", 256'(mem_read), 256'(0));
    chk("midrst_mem_address", 256'(mem_address), 256'(0));
    chk("midrst_line_cleared", d_pmem_rdata, 256'd0);
    repeat (8) @(negedge clk);
    run_txn(0, 1, 0, 0, 0, 32'd0, 32'h0000_8020, 256'd0, lat);

    // Randomised mix of scenarios.
    idle_noise = 1'b1;
    for (int t = 0; t < 50 && !abort_run; t++) begin
      resp_pct = $urandom_range(40, 100);
      typ = $urandom_range(0, 5);
      ai = 32'h0000_4000 + 32'($urandom_range(0, 15) << 5) + 32'($urandom_range(0, 31));
      ad = 32'h0000_4000 + 32'($urandom_range(0, 15) << 5) + 32'($urandom_range(0, 31));
      case (typ)
        0:       run_txn(1, 0, 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), ai, ad, rand256(), lat);
        1:       run_txn(0, 1, 0, 0, 1'($urandom_range(0, 1)), ai, ad, rand256(), lat);
        2:       run_txn(0, 0, 1, 0, 1'($urandom_range(0, 1)), ai, ad, rand256(), lat);
        3:       run_txn(0, 1, 1, 0, 1'($urandom_range(0, 1)), ai, ad, rand256(), lat);
        4:       run_txn(1, 1, 0, 0, 1'($urandom_range(0, 1)), ai, ad, rand256(), lat);
        default: run_txn(1, 0, 1, 0, 1'($urandom_range(0, 1)), ai, ad, rand256(), lat);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("expected_drained", 256'(exp_q.size()), 256'(0));
    chk("observed_drained", 256'(obs_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
